// File: rtl/mant_normalizer.sv
// FP32 adder back end: sums the aligned mantissas, normalizes, rounds to nearest-even and packs the result.
// Optional macro FAST_NORM_EN selects a one-cycle leading-zero normalize in place of the iterative NORM_STEP shifter.
module mant_normalizer #(
    parameter int NORM_STEP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [49:0] op_1_f_pr,
    input  logic [49:0] op_2_f_pr,
    input  logic        res_sig,
    input  logic [7:0]  exp_base,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] res,
    output logic        ovf
);
    typedef enum logic [2:0] {IDLE, ADD, NORM, ROUND, DONE} state_t;

    state_t      state_reg, state_next;
    logic [49:0] op1_reg, op2_reg;
    logic        sig_reg;
    logic [7:0]  eb_reg;
    logic [47:0] sum_reg;
    logic [8:0]  exp_reg;
    logic        sign_reg;
    logic [31:0] res_reg;
    logic        ovf_reg;

    logic [49:0] add_raw, add_mag;
    logic        add_neg, add_zero;
    logic [8:0]  lz, room, amt, exp_shift;
    logic [47:0] sum_shift;
    logic        norm_done;
    logic        rnd_inc, rnd_hidden, rnd_ovf;
    logic [24:0] rnd_sig;
    logic [8:0]  rnd_exp;

    // Magnitude of the two's complement sum; the sign flip is folded into sign_reg.
    always_comb begin
        add_raw  = op1_reg + op2_reg;
        add_neg  = add_raw[49];
        add_mag  = add_neg ? (~add_raw + 50'd1) : add_raw;
        add_zero = (add_mag == 50'd0);
    end

    always_comb begin
        lz = 9'd48;
        for (int i = 0; i < 48; i++) begin
            if (sum_reg[i]) lz = 9'(47 - i);
        end
        norm_done = sum_reg[47] || (exp_reg <= 9'd1);
        room      = (exp_reg > 9'd1) ? (exp_reg - 9'd1) : 9'd0;
        amt       = (lz < room) ? lz : room;
`ifndef FAST_NORM_EN
        if (amt > 9'(NORM_STEP)) amt = 9'(NORM_STEP);
`endif
        sum_shift = sum_reg << amt;
        exp_shift = exp_reg - amt;
    end

    // A carry out of the 24-bit significand either bumps a normal exponent or promotes a denormal to exp 1.
    always_comb begin
        rnd_inc    = sum_reg[23] && ((|sum_reg[22:0]) || sum_reg[24]);
        rnd_sig    = {1'b0, sum_reg[47:24]} + {24'd0, rnd_inc};
        rnd_hidden = rnd_sig[24] || rnd_sig[23];
        rnd_exp    = exp_reg + {8'd0, rnd_sig[24]};
        rnd_ovf    = rnd_hidden && (rnd_exp >= 9'd255);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (in_valid) state_next = ADD;
            ADD:   state_next = add_zero ? DONE : NORM;
`ifdef FAST_NORM_EN
            NORM:  state_next = ROUND;
`else
            NORM:  if (norm_done) state_next = ROUND;
`endif
            ROUND: state_next = DONE;
            DONE:  if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_reg == IDLE);
        out_valid = (state_reg == DONE);
        res       = res_reg;
        ovf       = ovf_reg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op1_reg  <= '0;
            op2_reg  <= '0;
            sig_reg  <= 1'b0;
            eb_reg   <= '0;
            sum_reg  <= '0;
            exp_reg  <= '0;
            sign_reg <= 1'b0;
            res_reg  <= '0;
            ovf_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        op1_reg <= op_1_f_pr;
                        op2_reg <= op_2_f_pr;
                        sig_reg <= res_sig;
                        eb_reg  <= exp_base;
                    end
                end
                ADD: begin
                    // Bit 0 stays sticky when the carry bit is shifted back into the hidden position.
                    sum_reg  <= add_mag[48] ? {add_mag[48:2], add_mag[1] | add_mag[0]} : add_mag[47:0];
                    exp_reg  <= {1'b0, eb_reg} + {8'd0, add_mag[48]};
                    sign_reg <= sig_reg ^ add_neg;
                    if (add_zero) begin
                        res_reg <= 32'h0000_0000;
                        ovf_reg <= 1'b0;
                    end
                end
                NORM: begin
                    sum_reg <= sum_shift;
                    exp_reg <= exp_shift;
                end
                ROUND: begin
                    if (rnd_ovf) begin
                        res_reg <= {sign_reg, 8'hFF, 23'h0};
                        ovf_reg <= 1'b1;
                    end else begin
                        res_reg <= {sign_reg, rnd_hidden ? rnd_exp[7:0] : 8'h00, rnd_sig[22:0]};
                        ovf_reg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mant_normalizer.sv
// Directed bench for mant_normalizer: a real-value rounding model plus a per-cycle output compare process.
module tb_mant_normalizer;
    localparam int STEP = 1;
`ifdef FAST_NORM_EN
    localparam int CANCEL_LAT = 4;
`else
    localparam int CANCEL_LAT = (STEP == 1) ? 7 : -1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, res_sig, out_valid, out_ready, ovf;
    logic [49:0] op_1_f_pr, op_2_f_pr;
    logic [7:0]  exp_base;
    logic [31:0] res;

    always #5 clk = ~clk;

    mant_normalizer #(.NORM_STEP(STEP)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op_1_f_pr(op_1_f_pr), .op_2_f_pr(op_2_f_pr), .res_sig(res_sig),
        .exp_base(exp_base), .out_valid(out_valid), .out_ready(out_ready),
        .res(res), .ovf(ovf)
    );

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        int          lat;
        int          acc;
        int          id;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   next_id = 0;
    int   lat_id = -1;

    // Round the exact value |a+b| * 2^(eb-127-47) to FP32 nearest-even, denormals floored at exponent 1.
    function automatic exp_t model(input logic [49:0] o1, input logic [49:0] o2,
                                   input logic sg, input logic [7:0] eb);
        exp_t        r;
        longint      a, b, s;
        logic [63:0] m, q, rem, half;
        logic        sign;
        int          p, e, h, sh, shift_need, norm_cyc;
        a = $signed(o1);
        b = $signed(o2);
        s = a + b;
        sign = sg ^ (s < 0);
        m = (s < 0) ? 64'(-s) : 64'(s);
        r.acc = 0;
        r.id = 0;
        if (m == 64'd0) begin
            r.res = 32'h0;
            r.ovf = 1'b0;
            r.lat = 2;
            return r;
        end
        p = 0;
        for (int i = 0; i < 64; i++) if (m[i]) p = i;
        e = int'(eb) + p - 47;
        if (e >= 1) h = p;
        else begin
            e = 1;
            h = 48 - int'(eb);
        end
        sh = h - 23;
        if (sh > 0) begin
            q = m >> sh;
            rem = m & ((64'd1 << sh) - 64'd1);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 64'd1;
        end else begin
            q = m << (-sh);
        end
        if (q[24]) begin
            q = q >> 1;
            e = e + 1;
        end
        r.ovf = 1'b0;
        if (q[23] && e >= 255) begin
            r.res = {sign, 8'hFF, 23'h0};
            r.ovf = 1'b1;
        end else if (q[23]) r.res = {sign, 8'(e), q[22:0]};
        else                r.res = {sign, 8'h00, q[22:0]};
        shift_need = (p >= 48) ? 0 : ((47 - p) < (int'(eb) - 1) ? (47 - p) : (int'(eb) - 1));
`ifdef FAST_NORM_EN
        norm_cyc = 1;
`else
        norm_cyc = (shift_need + STEP - 1) / STEP + 1;
`endif
        r.lat = 3 + norm_cyc;
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        exp_t e;
        if (rst) exp_q.delete();
        else begin
            cyc++;
            if (out_valid && out_ready && exp_q.size() > 0) begin
                $display("[TB] tx %0d done: res=%h ovf=%b", exp_q[0].id, res, ovf);
                void'(exp_q.pop_front());
            end
            if (in_valid && in_ready) begin
                e = model(op_1_f_pr, op_2_f_pr, res_sig, exp_base);
                e.acc = cyc;
                e.id = next_id;
                next_id++;
                exp_q.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        int lat;
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL stale_out: out_valid=1 with nothing pending, res=%h", res);
            end else begin
                tests++;
                if (res !== exp_q[0].res || ovf !== exp_q[0].ovf) begin
                    fails++;
                    $display("FAIL result tx %0d: got res=%h ovf=%b, expected res=%h ovf=%b",
                             exp_q[0].id, res, ovf, exp_q[0].res, exp_q[0].ovf);
                end
                tests++;
                if (in_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL in_ready_done tx %0d: got %b, expected 0", exp_q[0].id, in_ready);
                end
                if (lat_id != exp_q[0].id) begin
                    lat_id = exp_q[0].id;
                    lat = cyc - exp_q[0].acc + 1;
                    tests++;
                    if (lat != exp_q[0].lat) begin
                        fails++;
                        $display("FAIL latency tx %0d: got %0d, expected %0d", exp_q[0].id, lat, exp_q[0].lat);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, want);
        end
    endtask

    task automatic run(input string name, input logic [49:0] a, input logic [49:0] b,
                       input logic sg, input logic [7:0] eb, input logic [31:0] lit_res,
                       input logic lit_ovf, input int lit_lat, input int hold);
        exp_t m;
        int   n;
        m = model(a, b, sg, eb);
        chk({name, "_model_res"}, m.res, lit_res);
        chk({name, "_model_ovf"}, {31'd0, m.ovf}, {31'd0, lit_ovf});
        if (lit_lat > 0) chk({name, "_model_lat"}, 32'(m.lat), 32'(lit_lat));
        @(negedge clk);
        op_1_f_pr = a;
        op_2_f_pr = b;
        res_sig   = sg;
        exp_base  = eb;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL %s_accept: in_ready never rose", name);
        end
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: out_valid got 0, expected 1 within 200 cycles", name);
            exp_q.delete();
        end
        repeat (hold) @(negedge clk);
        out_ready = 1'b1;
        n = 0;
        while (out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [49:0] one;
        one = 50'd1 << 47;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        op_1_f_pr = '0;
        op_2_f_pr = '0;
        res_sig = 1'b0;
        exp_base = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_res", res, 32'h0);
        chk("reset_ovf", {31'd0, ovf}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run("one_plus_one", one, one, 1'b0, 8'd127, 32'h4000_0000, 1'b0, 4, 0);
        run("hold_done", one, one, 1'b0, 8'd127, 32'h4000_0000, 1'b0, 4, 5);
        run("cancel", one, (~one + 50'd1) + (50'd1 << 44), 1'b0, 8'd127, 32'h3E00_0000, 1'b0, CANCEL_LAT, 0);
        run("tie_even", one | (50'd1 << 23), 50'd0, 1'b0, 8'd127, 32'h3F80_0000, 1'b0, 4, 0);
        run("round_up", one | (50'd1 << 24) | (50'd1 << 23), 50'd0, 1'b0, 8'd127, 32'h3F80_0002, 1'b0, 4, 0);
        run("ovf_carry", one, one, 1'b0, 8'd254, 32'h7F80_0000, 1'b1, 4, 0);
        run("zero", one, ~one + 50'd1, 1'b1, 8'd127, 32'h0000_0000, 1'b0, 2, 0);
        run("denormal", 50'd1 << 32, 50'd0, 1'b0, 8'd1, 32'h0000_0100, 1'b0, 4, 0);
        run("neg_sum", ~one + 50'd1, 50'd1 << 46, 1'b0, 8'd127, 32'hBF00_0000, 1'b0, -1, 0);
        run("ovf_round", {2'b00, 24'hFFFFFF, 24'h800000}, 50'd0, 1'b0, 8'd254, 32'h7F80_0000, 1'b1, 4, 0);
        run("denorm_to_norm", {2'b00, 24'h7FFFFF, 24'h800001}, 50'd0, 1'b0, 8'd1, 32'h0080_0000, 1'b0, 4, 0);
        run("carry_sticky", (50'd1 << 48) | (50'd1 << 24), 50'd1, 1'b0, 8'd127, 32'h4000_0001, 1'b0, 4, 0);
        run("big_shift", 50'd1 << 10, 50'd0, 1'b1, 8'd127, 32'hAD00_0000, 1'b0, -1, 0);
        run("part_denorm", 50'd1 << 20, 50'd0, 1'b0, 8'd5, 32'h0000_0001, 1'b0, -1, 0);

        // Abort an operation while it sits in NORM.
        @(negedge clk);
        op_1_f_pr = 50'd1 << 10;
        op_2_f_pr = 50'd0;
        exp_base  = 8'd127;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_mid_res", res, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        run("after_reset", one, one, 1'b0, 8'd127, 32'h4000_0000, 1'b0, 4, 0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
